jtag_mem_arbiter: RTL and testbench
===================================

# jtag_mem_arbiter

Shares the single-port program/data RAM between the Minion CPU bus and the JTAG debug memory path (USER1 ROM/RAM access chain). CPU accesses have fixed priority. A JTAG access request arrives as a toggle from the TCK domain. The block synchronises it, holds it pending, and inserts it into a free memory cycle or a forced slot once a starvation limit is reached. It then returns read data and a toggle acknowledge.

## Interface
- ADDR_W, 14, word-address width of RAM and both requesters
- STARVE_MAX, 15, cycles a pending JTAG access may be blocked by CPU_REQ before it is forced (0..255; 0 = JTAG always wins)

- CLK  in  1  system clock; the block's only clock
- RESET  in  1  synchronous, active-high reset
- CPU_REQ  in  1  CPU access request, level, this cycle
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADDR  in  ADDR_W  CPU word address
- CPU_WDATA  in  32  CPU write data
- CPU_GNT  out  1  combinational; CPU access taken by RAM this cycle
- CPU_RVALID  out  1  registered; CPU_RDATA valid
- CPU_RDATA  out  32  equals MEM_RDATA
- JTAG_REQ_TGL  in  1  asynchronous; each transition requests one access
- JTAG_WE  in  1  stable from toggle until ack toggle
- JTAG_ADDR  in  ADDR_W  stable from toggle until ack toggle
- JTAG_WDATA  in  32  stable from toggle until ack toggle
- JTAG_ACK_TGL  out  1  toggles once per completed JTAG access
- JTAG_RDATA  out  32  registered read data of last JTAG read
- JTAG_BUSY  out  1  state != IDLE
- MEM_EN  out  1  RAM enable
- MEM_WE  out  1  RAM write enable
- MEM_ADDR  out  ADDR_W  RAM address
- MEM_WDATA  out  32  RAM write data
- MEM_RDATA  in  32  RAM read data, one cycle after MEM_EN with !MEM_WE

## Operation
- Synchroniser: sync0 and sync1 register JTAG_REQ_TGL. prev holds the last consumed level.
  - req_edge = sync1 ^ prev.
  - prev loads sync1 only in IDLE when req_edge = 1. An edge arriving while busy therefore stays visible, and exactly one further request is queued.
- States: IDLE, JPEND, JDATA.
  - IDLE, req_edge = 1: capture JTAG_WE/ADDR/WDATA into hold registers, clear starve count, go to JPEND.
  - JPEND: jtag_slot = !CPU_REQ | (count == STARVE_MAX).
    - jtag_slot = 1: go to JDATA.
    - Otherwise: count increments, saturating at STARVE_MAX.
  - JDATA: if the held op is a read, JTAG_RDATA <= MEM_RDATA. Always: JTAG_ACK_TGL inverts, go to IDLE.
- Mux, combinational:
  - jtag_slot = 1: MEM_EN = 1 and MEM_WE/ADDR/WDATA come from the hold registers.
  - Otherwise: MEM_EN = CPU_REQ and MEM_* come from the CPU fields.
  - CPU_GNT = CPU_REQ & !jtag_slot.
- CPU_RVALID <= CPU_GNT & !CPU_WE. No CPU write response.
- CPU must hold REQ/fields until GNT.

## Timing
- Reset: all of the following are 0, and the FSM is in IDLE:
  - registered outputs: CPU_RVALID, JTAG_ACK_TGL, JTAG_RDATA
  - internal registers: sync0, sync1, prev, count, hold registers
- Outputs during RESET:
  - JTAG_BUSY = 0.
  - MEM_* and CPU_GNT follow the CPU inputs combinationally.
- JTAG latency with CPU idle, taking input toggle before edge 0 as the reference:
  - sync0 at edge 0, sync1 at edge 1.
  - JPEND after edge 2; RAM access issued in that cycle.
  - JDATA after edge 3.
  - ACK toggles and JTAG_RDATA updates at edge 4.
- Each blocked JPEND cycle adds 1 cycle. Worst case is STARVE_MAX extra cycles.
- CPU read: granted cycle N, CPU_RVALID and RDATA in cycle N+1. Zero-wait when no JTAG slot.
- Simultaneous CPU_REQ and forced slot: JTAG wins and CPU_GNT = 0. The CPU retries next cycle and is never blocked two consecutive cycles, because JDATA never takes the RAM.
- Toggle while busy: serviced right after return to IDLE; JPEND is reached the cycle after IDLE.
- Reset mid-access: the access is abandoned and no ack toggle is issued. The JTAG side is reset alongside by the system.

## Test plan
- CPU write 0xDEADBEEF @0x010, then read @0x010 -> GNT same cycle each, RVALID next cycle with RDATA 0xDEADBEEF.
- JTAG write 0x12345678 @0x020 with CPU idle, then JTAG read @0x020 -> ACK toggles 4 cycles after each REQ toggle; JTAG_RDATA = 0x12345678.
- CPU_REQ held continuously, JTAG read pending, STARVE_MAX = 15 -> exactly one cycle with CPU_GNT = 0, after 15 blocked JPEND cycles. ACK then follows and CPU_GNT returns next cycle.
- STARVE_MAX = 0 with CPU_REQ high -> JTAG access on first JPEND cycle; CPU stalls one cycle.
- Second REQ toggle issued while JPEND -> two ACK toggles, two RAM accesses, none lost.
- RESET asserted in JPEND -> IDLE, BUSY = 0, ACK unchanged, RVALID = 0 next cycle.

Source files
------------

// File: rtl/jtag_mem_arbiter.sv
// jtag_mem_arbiter: shares the single-port RAM between the CPU bus (fixed
// priority) and the JTAG debug path, with a starvation-limited forced slot.
module jtag_mem_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [31:0]       CPU_WDATA,
    output logic              CPU_GNT,
    output logic              CPU_RVALID,
    output logic [31:0]       CPU_RDATA,
    input  logic              JTAG_REQ_TGL,
    input  logic              JTAG_WE,
    input  logic [ADDR_W-1:0] JTAG_ADDR,
    input  logic [31:0]       JTAG_WDATA,
    output logic              JTAG_ACK_TGL,
    output logic [31:0]       JTAG_RDATA,
    output logic              JTAG_BUSY,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA
);

    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JPEND = 2'd1,
        JDATA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sync0_q, sync1_q;
    logic                prev_q, prev_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                hold_we_q, hold_we_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [31:0]         hold_wdata_q, hold_wdata_d;
    logic                ack_q, ack_d;
    logic [31:0]         jrdata_q, jrdata_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;

    logic                req_edge;
    logic                jtag_slot;

    // Pending request is the difference between synchronised and consumed level.
    assign req_edge  = sync1_q ^ prev_q;

    // JTAG owns the RAM when CPU is idle or the starvation limit is reached.
    assign jtag_slot = !RESET && (state_q == JPEND) &&
                       (!CPU_REQ || (count_q == STARVE_LIM));

    // RAM mux and CPU grant.
    always_comb begin
        MEM_EN    = CPU_REQ;
        MEM_WE    = CPU_WE;
        MEM_ADDR  = CPU_ADDR;
        MEM_WDATA = CPU_WDATA;
        if (jtag_slot) begin
            MEM_EN    = 1'b1;
            MEM_WE    = hold_we_q;
            MEM_ADDR  = hold_addr_q;
            MEM_WDATA = hold_wdata_q;
        end
    end

    assign CPU_GNT      = CPU_REQ && !jtag_slot;
    assign CPU_RDATA    = MEM_RDATA;
    assign CPU_RVALID   = cpu_rvalid_q;
    assign JTAG_ACK_TGL = ack_q;
    assign JTAG_RDATA   = jrdata_q;
    assign JTAG_BUSY    = !RESET && (state_q != IDLE);

    // Next-state and register updates for the JTAG access sequencer.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        count_d      = count_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        ack_d        = ack_q;
        jrdata_d     = jrdata_q;
        cpu_rvalid_d = CPU_GNT && !CPU_WE;

        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    prev_d       = sync1_q;
                    hold_we_d    = JTAG_WE;
                    hold_addr_d  = JTAG_ADDR;
                    hold_wdata_d = JTAG_WDATA;
                    count_d      = '0;
                    state_d      = JPEND;
                end
            end
            JPEND: begin
                if (jtag_slot) begin
                    state_d = JDATA;
                end else if (count_q != STARVE_LIM) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            JDATA: begin
                if (!hold_we_q) begin
                    jrdata_d = MEM_RDATA;
                end
                ack_d   = !ack_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            sync0_q      <= 1'b0;
            sync1_q      <= 1'b0;
            prev_q       <= 1'b0;
            count_q      <= '0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            ack_q        <= 1'b0;
            jrdata_q     <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync0_q      <= JTAG_REQ_TGL;
            sync1_q      <= sync0_q;
            prev_q       <= prev_d;
            count_q      <= count_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            ack_q        <= ack_d;
            jrdata_q     <= jrdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// Directed bench for jtag_mem_arbiter: main instance (STARVE_MAX=15) with a
// RAM model, plus a STARVE_MAX=0 instance sharing the same requester inputs.
module tb_jtag_mem_arbiter;

    localparam int unsigned ADDR_W = 14;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CPU_REQ, CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [31:0]       CPU_WDATA;
    logic              JTAG_REQ_TGL, JTAG_WE;
    logic [ADDR_W-1:0] JTAG_ADDR;
    logic [31:0]       JTAG_WDATA;

    logic              CPU_GNT, CPU_RVALID, JTAG_ACK_TGL, JTAG_BUSY;
    logic [31:0]       CPU_RDATA, JTAG_RDATA, MEM_WDATA, MEM_RDATA;
    logic              MEM_EN, MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;

    logic              gnt0, rvalid0, ack0, busy0, men0, mwe0;
    logic [31:0]       crd0, jrd0, mwd0;
    logic [ADDR_W-1:0] madr0;
    logic [31:0]       mrd0 = 32'h0BAD_F00D;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    jtag_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(15)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
        .JTAG_REQ_TGL(JTAG_REQ_TGL), .JTAG_WE(JTAG_WE), .JTAG_ADDR(JTAG_ADDR),
        .JTAG_WDATA(JTAG_WDATA), .JTAG_ACK_TGL(JTAG_ACK_TGL), .JTAG_RDATA(JTAG_RDATA),
        .JTAG_BUSY(JTAG_BUSY),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    jtag_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(gnt0), .CPU_RVALID(rvalid0), .CPU_RDATA(crd0),
        .JTAG_REQ_TGL(JTAG_REQ_TGL), .JTAG_WE(JTAG_WE), .JTAG_ADDR(JTAG_ADDR),
        .JTAG_WDATA(JTAG_WDATA), .JTAG_ACK_TGL(ack0), .JTAG_RDATA(jrd0),
        .JTAG_BUSY(busy0),
        .MEM_EN(men0), .MEM_WE(mwe0), .MEM_ADDR(madr0), .MEM_WDATA(mwd0),
        .MEM_RDATA(mrd0)
    );

    // Single-port RAM model with one-cycle read latency.
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
            else        MEM_RDATA     <= ram[MEM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one JTAG access and return the edge index at which ACK toggled.
    task automatic jtag_op(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, output int lat);
        logic a;
        a            = JTAG_ACK_TGL;
        JTAG_WE      = we;
        JTAG_ADDR    = addr;
        JTAG_WDATA   = wdata;
        JTAG_REQ_TGL = !JTAG_REQ_TGL;
        lat          = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (JTAG_ACK_TGL != a) begin
                lat = i;
                break;
            end
        end
        tick();
    endtask

    initial begin
        int lat;
        int first_low, n_low, ack_i, first_low0, n_low0, ack_i0, n_ack, n_men;
        logic a, a0, rv18, rv19;

        RESET = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'b1;
        CPU_ADDR = 14'h0055; CPU_WDATA = 32'h0;
        JTAG_REQ_TGL = 1'b0; JTAG_WE = 1'b0; JTAG_ADDR = '0; JTAG_WDATA = '0;
        tick(); tick();
        chk("rst_gnt",    32'(CPU_GNT), 32'd1);
        chk("rst_mem_en", 32'(MEM_EN), 32'd1);
        chk("rst_addr",   32'(MEM_ADDR), 32'h55);
        chk("rst_busy",   32'(JTAG_BUSY), 32'd0);
        CPU_REQ = 1'b0;
        tick();
        RESET = 1'b0;
        chk("rst_rvalid", 32'(CPU_RVALID), 32'd0);
        chk("rst_ack",    32'(JTAG_ACK_TGL), 32'd0);
        chk("rst_jrdata", JTAG_RDATA, 32'd0);
        tick();

        // CPU write then read
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h010; CPU_WDATA = 32'hDEADBEEF;
        #1;
        chk("cpu_wr_gnt", 32'(CPU_GNT), 32'd1);
        chk("cpu_wr_mem", {30'd0, MEM_EN, MEM_WE}, 32'd3);
        tick();
        CPU_WE = 1'b0;
        #1;
        chk("cpu_rd_gnt", 32'(CPU_GNT), 32'd1);
        chk("cpu_wr_norv", 32'(CPU_RVALID), 32'd0);
        tick();
        CPU_REQ = 1'b0;
        chk("cpu_rd_rv",   32'(CPU_RVALID), 32'd1);
        chk("cpu_rd_data", CPU_RDATA, 32'hDEADBEEF);
        tick();
        chk("cpu_rv_drop", 32'(CPU_RVALID), 32'd0);

        // JTAG write then read with CPU idle
        jtag_op(1'b1, 14'h020, 32'h12345678, lat);
        chk("jwr_lat", 32'(lat), 32'd4);
        chk("jwr_ram", ram[14'h020], 32'h12345678);
        jtag_op(1'b0, 14'h020, 32'h0, lat);
        chk("jrd_lat",  32'(lat), 32'd4);
        chk("jrd_data", JTAG_RDATA, 32'h12345678);
        chk("jrd_ack",  32'(JTAG_ACK_TGL), 32'd0);
        chk("jrd0_data", jrd0, 32'h0BADF00D);

        // Starvation: CPU reads continuously, JTAG read pending
        a = JTAG_ACK_TGL; a0 = ack0;
        first_low = -1; n_low = 0; ack_i = -1;
        first_low0 = -1; n_low0 = 0; ack_i0 = -1;
        rv18 = 1'b1; rv19 = 1'b0;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h010;
        JTAG_WE = 1'b0; JTAG_ADDR = 14'h010;
        JTAG_REQ_TGL = !JTAG_REQ_TGL;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (!CPU_GNT) begin
                n_low++;
                if (first_low < 0) first_low = i;
            end
            if (!gnt0) begin
                n_low0++;
                if (first_low0 < 0) first_low0 = i;
            end
            if (JTAG_ACK_TGL != a && ack_i < 0) ack_i = i;
            if (ack0 != a0 && ack_i0 < 0) ack_i0 = i;
            if (i == 18) rv18 = CPU_RVALID;
            if (i == 19) rv19 = CPU_RVALID;
        end
        CPU_REQ = 1'b0;
        chk("starve_nlow",  32'(n_low), 32'd1);
        chk("starve_first", 32'(first_low), 32'd17);
        chk("starve_ack",   32'(ack_i), 32'd19);
        chk("starve_rv18",  32'(rv18), 32'd0);
        chk("starve_rv19",  32'(rv19), 32'd1);
        chk("starve_data",  JTAG_RDATA, 32'hDEADBEEF);
        chk("sm0_nlow",     32'(n_low0), 32'd1);
        chk("sm0_first",    32'(first_low0), 32'd2);
        chk("sm0_ack",      32'(ack_i0), 32'd4);
        tick();

        // Second toggle while the first is pending
        a = JTAG_ACK_TGL; n_ack = 0; n_men = 0;
        JTAG_WE = 1'b0; JTAG_ADDR = 14'h020;
        JTAG_REQ_TGL = !JTAG_REQ_TGL;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 2) begin
                chk("dbl_busy", 32'(JTAG_BUSY), 32'd1);
                JTAG_REQ_TGL = !JTAG_REQ_TGL;
            end
            if (MEM_EN) n_men++;
            if (JTAG_ACK_TGL != a) begin
                n_ack++;
                a = JTAG_ACK_TGL;
            end
        end
        chk("dbl_acks", 32'(n_ack), 32'd2);
        chk("dbl_mem",  32'(n_men), 32'd2);
        chk("dbl_data", JTAG_RDATA, 32'h12345678);
        chk("dbl_idle", 32'(JTAG_BUSY), 32'd0);

        jtag_op(1'b1, 14'h040, 32'hA5A5A5A5, lat);
        chk("jwr2_lat", 32'(lat), 32'd4);
        chk("jwr2_ram", ram[14'h040], 32'hA5A5A5A5);

        // Reset while JPEND
        a = JTAG_ACK_TGL;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h010;
        JTAG_WE = 1'b0; JTAG_ADDR = 14'h020;
        JTAG_REQ_TGL = !JTAG_REQ_TGL;
        for (int i = 0; i < 6; i++) tick();
        chk("rj_busy_pre", 32'(JTAG_BUSY), 32'd1);
        RESET = 1'b1; JTAG_REQ_TGL = 1'b0;
        #1;
        chk("rj_busy_rst", 32'(JTAG_BUSY), 32'd0);
        chk("rj_gnt_rst",  32'(CPU_GNT), 32'd1);
        tick();
        RESET = 1'b0; CPU_REQ = 1'b0;
        chk("rj_rvalid", 32'(CPU_RVALID), 32'd0);
        chk("rj_busy",   32'(JTAG_BUSY), 32'd0);
        chk("rj_ack",    32'(JTAG_ACK_TGL), 32'(a));
        for (int i = 0; i < 8; i++) tick();
        chk("rj_ack_late",  32'(JTAG_ACK_TGL), 32'(a));
        chk("rj_busy_late", 32'(JTAG_BUSY), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
